// File: rtl/lut_fn_pkg.sv
// lut_fn_engine shared types.
// Sweep FSM states and the default truth table.
package lut_fn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH
  } state_t;

  // F=0 only at 0,1,2,8,10,12,14
  localparam logic [15:0] DEF_TT = 16'hAAF8;

endpackage

// File: rtl/lut_fn_outslot.sv
// One-entry ready/valid output register.
// Holds {f, idx, last} stable until the consumer takes it.
module lut_fn_outslot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         f,
  input  logic [W-1:0] idx,
  input  logic         last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_f,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         free
);

  assign free = !out_valid || out_ready;

  // load a new beat, or retire the current one when it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_f     <= f;
      out_idx   <= idx;
      out_last  <= last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lut_fn_engine.sv
// Truth-table function unit with single eval and full sweep.
// Results leave through a one-entry ready/valid slot.
module lut_fn_engine
  import lut_fn_pkg::*;
#(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] INIT_TT = (2**N_IN)'(DEF_TT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tt_we,
  input  logic [2**N_IN-1:0] tt_wdata,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  output logic              in_ready,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_f,
  output logic [N_IN-1:0]   out_idx,
  output logic              out_last,
  output logic              done,
  output logic [N_IN:0]     ones_cnt
);

  localparam int TT_W = 2**N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(TT_W-1);
  localparam logic [N_IN:0] ONE  = (N_IN+1)'(1);

  state_t            state, state_n;
  logic [TT_W-1:0]   tt;
  logic [N_IN:0]     idx, idx_n;
  logic [N_IN:0]     acc, acc_n;
  logic              load, ld_f, ld_last, fin, free;
  logic [N_IN-1:0]   ld_idx;

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && !start && free;

  lut_fn_outslot #(.W(N_IN)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .f         (ld_f),
    .idx       (ld_idx),
    .last      (ld_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_f     (out_f),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .free      (free)
  );

  // next state, sweep counters and slot load
  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    load    = 1'b0;
    ld_f    = 1'b0;
    ld_idx  = '0;
    ld_last = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SWEEP;
          idx_n   = '0;
          acc_n   = '0;
        end else if (in_valid && free) begin
          load   = 1'b1;
          ld_f   = tt[in_vec];
          ld_idx = in_vec;
        end
      end
      SWEEP: begin
        if (free) begin
          load    = 1'b1;
          ld_f    = tt[idx[N_IN-1:0]];
          ld_idx  = idx[N_IN-1:0];
          ld_last = (idx == LAST);
          acc_n   = acc + (N_IN+1)'(ld_f);
          idx_n   = idx + ONE;
          if (idx == LAST) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (out_valid && out_ready && out_last) begin
          state_n = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, counters, table and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      tt       <= INIT_TT;
      done     <= 1'b0;
      ones_cnt <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      acc   <= acc_n;
      done  <= fin;
      if (tt_we && state == IDLE) tt <= tt_wdata;
      if (fin) ones_cnt <= acc;
    end
  end

endmodule

// File: tb/tb_lut_fn_engine.sv
// Randomised bench for lut_fn_engine.
// Scoreboard of expected beats built from a table model.
module tb_lut_fn_engine;

  localparam logic [15:0] INIT = 16'hAAF8;

  logic        clk = 1'b0;
  logic        rst_n, tt_we, in_valid, start, out_ready;
  logic [15:0] tt_wdata;
  logic [3:0]  in_vec;
  logic        in_ready, busy, out_valid, out_f, out_last, done;
  logic [3:0]  out_idx;
  logic [4:0]  ones_cnt;

  lut_fn_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tt_we     (tt_we),
    .tt_wdata  (tt_wdata),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors = 0;
  logic [6:0]  q[$];
  logic [15:0] mtt;
  bit          mbusy, done_pend, hold_pend, lat_pend;
  logic [6:0]  hold_beat;
  int          ones_exp, ones_run;
  int          mode, cyc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mbusy     = 0;
    done_pend = 0;
    hold_pend = 0;
    lat_pend  = 0;
    mtt       = INIT;
  endtask

  task automatic step();
    logic [6:0] e, obs;
    bit fire, cur_busy;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    @(negedge clk);
    obs      = {out_f, out_idx, out_last};
    fire     = out_valid && out_ready;
    cur_busy = mbusy;
    if (hold_pend) check("hold", {out_valid, obs}, {1'b1, hold_beat});
    if (lat_pend) check("lat", out_valid, 1);
    check("busy", busy, mbusy);
    check("done", done, done_pend);
    if (done_pend) check("ones", ones_cnt, ones_exp);
    check("rdy", in_ready, !mbusy && !start && (!out_valid || out_ready));
    done_pend = 0;
    lat_pend  = 0;
    if (fire) begin
      if (q.size() == 0) begin
        check("spur", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("beat", obs, e);
        if (e[0]) begin
          done_pend = 1;
          ones_exp  = ones_run;
          mbusy     = 0;
        end
      end
    end
    if (!cur_busy && start) begin
      if (tt_we) mtt = tt_wdata;
      for (int i = 0; i < 16; i++)
        q.push_back({mtt[i], 4'(i), i == 15});
      ones_run = $countones(mtt);
      mbusy    = 1;
    end else if (!cur_busy) begin
      if (in_valid && (!out_valid || out_ready)) begin
        q.push_back({mtt[in_vec], in_vec, 1'b0});
        lat_pend = 1;
      end
      if (tt_we) mtt = tt_wdata;
    end
    hold_pend = out_valid && !out_ready;
    hold_beat = obs;
    @(posedge clk);
    #1;
    start    = 0;
    in_valid = 0;
    tt_we    = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mbusy || q.size() != 0 || done_pend) && n < 200) begin
      step();
      n++;
    end
    check("drain_tmo", n < 200, 1);
  endtask

  task automatic sweep(int m);
    mode  = m;
    start = 1;
    step();
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 0; tt_we = 0; tt_wdata = '0; in_valid = 0;
    in_vec = '0; start = 0; out_ready = 1; mode = 0; cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_f", out_f, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ones", ones_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1;

    // single evals
    mode = 0;
    in_valid = 1; in_vec = 4'd3; step(); step();
    in_valid = 1; in_vec = 4'd0; step(); step();

    // sweeps with free-flowing and stalled consumer
    sweep(0);
    sweep(1);

    // table write, then write ignored during sweep
    tt_we = 1; tt_wdata = 16'h0001; step();
    mode = 2; start = 1; step();
    tt_we = 1; tt_wdata = 16'hFFFF; step();
    drain();
    sweep(2);

    // write in the same cycle as start lands first
    tt_we = 1; tt_wdata = 16'h8000; mode = 0; start = 1; step();
    drain();

    // all-ones table reaches the top count
    tt_we = 1; tt_wdata = 16'hFFFF; step();
    sweep(1);

    // start and eval together: start wins
    tt_we = 1; tt_wdata = INIT; step();
    start = 1; in_valid = 1; in_vec = 4'd5; step();
    drain();

    // start while busy is ignored
    mode = 0; start = 1; step();
    start = 1; step();
    start = 1; step();
    drain();

    // randomised traffic
    mode = 2;
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_vec   = 4'($urandom);
      start    = ($urandom_range(0, 19) == 0);
      tt_we    = ($urandom_range(0, 9) == 0);
      tt_wdata = 16'($urandom);
      step();
    end
    drain();

    // reset mid-sweep
    mode = 0; start = 1; step();
    k = 0;
    while (!(out_valid && out_idx == 4'd7) && k < 40) begin
      step();
      k++;
    end
    check("reach7", out_idx, 7);
    rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_idx", out_idx, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ones", ones_cnt, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("arst_hold", {busy, done, out_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    step(); step();
    sweep(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
